// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding, line levels and a parity helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Parity over up to 9 data bits; narrower characters are zero-extended, which leaves the XOR unchanged.
  function automatic logic frame_parity(input logic [8:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port of the buffered UART transmitter: write strobe, character and status flags.
// Latency: n/a (signal bundle only).
// Backpressure: t_full tells the host to hold off; writes while full are dropped and flagged.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              t_enable;
  logic [DATA_W-1:0] data;
  logic              t_busy;
  logic              t_full;
  logic              t_overrun;

  modport master (
    output t_enable,
    output data,
    input  t_busy,
    input  t_full,
    input  t_overrun
  );

  modport slave (
    input  t_enable,
    input  data,
    output t_busy,
    output t_full,
    output t_overrun
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output; shared by the UART transmitter and receiver.
// Latency: a pushed word is visible on head/!empty the clk after the push.
// Backpressure: push ignored while full (evaluated pre-pop), pop ignored while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer advance; wrap-around is plain modulo arithmetic on AW+1 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: queues host characters and serialises start/data/[parity]/stop frames on txd.
// Latency: start-bit edge 1 clk after the first baud_enable that finds the FIFO non-empty.
// Backpressure: t_full stops pushes; a write while full is dropped and sets sticky t_overrun.
// Build option: define UART_TX_PARITY_EN to add a parity bit after the data bits (polarity from PARITY_ODD).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          baud_enable,
  uart_tx_fifo_if.slave host,
  output logic          txd
);
  localparam int               CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic             STOP_INIT = (STOP_BITS == 2);

  // Elaboration-time guards on the configuration.
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_fifo: DATA_W must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  tx_state_t         state_q;
  tx_state_t         state_d;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              stop_cnt_q;
  logic              txd_q;
  logic              overrun_q;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (host.t_enable),
    .push_data (host.data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; every transition waits for a baud tick.
  always_comb begin
    state_d = state_q;
    if (baud_enable) begin
      case (state_q)
        IDLE:   if (!fifo_empty) state_d = START;
        START:  state_d = DATA;
`ifdef UART_TX_PARITY_EN
        DATA:   if (bit_cnt_q == '0) state_d = PARITY;
        PARITY: state_d = STOP;
`else
        DATA:   if (bit_cnt_q == '0) state_d = STOP;
`endif
        STOP:   if (stop_cnt_q == 1'b0) state_d = fifo_empty ? IDLE : START;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pop decode: take the next character when idle or as the last stop period ends.
  always_comb begin
    fifo_pop = 1'b0;
    if (baud_enable && !fifo_empty) begin
      if (state_q == IDLE)                        fifo_pop = 1'b1;
      if (state_q == STOP && stop_cnt_q == 1'b0)  fifo_pop = 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_q;

  // Parity of the character is captured as it leaves the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         par_q <= 1'b0;
    else if (fifo_pop) par_q <= frame_parity(9'(fifo_head), PARITY_ODD != 0);
  end
`endif

  // Shift register, bit/stop counters and the registered txd line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txd_q      <= LINE_IDLE;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else if (baud_enable) begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            sh_q  <= fifo_head;
            txd_q <= LINE_START;
          end
        end
        START: begin
          txd_q     <= sh_q[0];
          sh_q      <= sh_q >> 1;
          bit_cnt_q <= LAST_BIT;
        end
        DATA: begin
          if (bit_cnt_q != '0) begin
            txd_q     <= sh_q[0];
            sh_q      <= sh_q >> 1;
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end else begin
`ifdef UART_TX_PARITY_EN
            txd_q      <= par_q;
`else
            txd_q      <= LINE_STOP;
            stop_cnt_q <= STOP_INIT;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          txd_q      <= LINE_STOP;
          stop_cnt_q <= STOP_INIT;
        end
`endif
        STOP: begin
          if (stop_cnt_q != 1'b0) begin
            stop_cnt_q <= stop_cnt_q - 1'b1;
          end else if (fifo_pop) begin
            // Back-to-back: next start bit follows the stop bit with no idle gap.
            sh_q  <= fifo_head;
            txd_q <= LINE_START;
          end else begin
            txd_q <= LINE_IDLE;
          end
        end
        default: txd_q <= LINE_IDLE;
      endcase
    end
  end

  // Sticky overrun: a write attempted while the FIFO is full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             overrun_q <= 1'b0;
    else if (host.t_enable && fifo_full)   overrun_q <= 1'b1;
  end

  assign txd            = txd_q;
  assign host.t_full    = fifo_full;
  assign host.t_overrun = overrun_q;
  assign host.t_busy    = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, parity, back-to-back, overrun, 7-bit/2-stop and mid-frame reset.
// Latency: bits sampled mid-period, 16 clks per baud period.
// Backpressure: exercises t_full and t_overrun with a write into a full FIFO.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baud_enable = 1'b0;
  logic txd_a;
  logic txd_b;
  logic txd_c;
  int   nvec = 0;
  int   nerr = 0;
  int   baud_cnt = 0;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB8 = 10 + PB;
  localparam int NB7 = 10 + PB;

  uart_tx_fifo_if #(.DATA_W(8)) if_a ();
  uart_tx_fifo_if #(.DATA_W(7)) if_b ();
  uart_tx_fifo_if #(.DATA_W(8)) if_c ();

  uart_tx_fifo #(.DATA_W(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_a (
    .clk(clk), .reset(reset), .baud_enable(baud_enable), .host(if_a), .txd(txd_a));
  uart_tx_fifo #(.DATA_W(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_b (
    .clk(clk), .reset(reset), .baud_enable(baud_enable), .host(if_b), .txd(txd_b));
  uart_tx_fifo #(.DATA_W(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1)) u_c (
    .clk(clk), .reset(reset), .baud_enable(baud_enable), .host(if_c), .txd(txd_c));

  always #5 clk = ~clk;

  // Baud tick every 16 clks, changed 2 ns after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      baud_cnt    = (baud_cnt + 1) % 16;
      baud_enable = (baud_cnt == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic txd_of(input int sel);
    if (sel == 0) return txd_a;
    if (sel == 1) return txd_b;
    return txd_c;
  endfunction

  function automatic logic busy_of(input int sel);
    if (sel == 0) return if_a.t_busy;
    if (sel == 1) return if_b.t_busy;
    return if_c.t_busy;
  endfunction

  // Even-parity 8-bit frame, bit 0 = start bit.
  function automatic logic [15:0] frame8(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {5'b0, 1'b1, ^d, d, 1'b0};
`else
    return {6'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic write_byte(input int sel, input logic [7:0] d);
    if (sel == 0)      begin if_a.t_enable = 1'b1; if_a.data = d;      end
    else if (sel == 1) begin if_b.t_enable = 1'b1; if_b.data = d[6:0]; end
    else               begin if_c.t_enable = 1'b1; if_c.data = d;      end
    @(negedge clk);
    if_a.t_enable = 1'b0; if_b.t_enable = 1'b0; if_c.t_enable = 1'b0;
    if_a.data = '1; if_b.data = '1; if_c.data = '1;
  endtask

  task automatic wait_start(input int sel, input int maxwait, output int w);
    w = -1;
    for (int i = 1; i <= maxwait; i++) begin
      @(negedge clk);
      if (txd_of(sel) === 1'b0) begin
        w = i;
        break;
      end
    end
  endtask

  task automatic capture(input int sel, input int nbits, input int maxwait,
                         output logic [15:0] bits, output int w);
    bits = '0;
    wait_start(sel, maxwait, w);
    if (w < 0) return;
    repeat (7) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bits[i] = txd_of(sel);
      if (i != nbits - 1) repeat (16) @(negedge clk);
    end
  endtask

  task automatic wait_busy_fall(input int sel, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy_of(sel) === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    if_a.t_enable = 1'b0; if_b.t_enable = 1'b0; if_c.t_enable = 1'b0;
    if_a.data = '0; if_b.data = '0; if_c.data = '0;
    repeat (3) @(negedge clk);
    nvec++; if (txd_a !== 1'b1) begin nerr++; $display("FAIL rst_txd: got %b want 1", txd_a); end
    nvec++; if (if_a.t_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", if_a.t_busy); end
    nvec++; if (if_a.t_full !== 1'b0) begin nerr++; $display("FAIL rst_full: got %b want 0", if_a.t_full); end
    nvec++; if (if_a.t_overrun !== 1'b0) begin nerr++; $display("FAIL rst_ovr: got %b want 0", if_a.t_overrun); end
    nvec++; if (txd_b !== 1'b1) begin nerr++; $display("FAIL rst_txd_b: got %b want 1", txd_b); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_8n1;
    logic [15:0] bits;
    int w;
    int n;
    write_byte(0, 8'hA5);
    nvec++; if (if_a.t_busy !== 1'b1) begin nerr++; $display("FAIL busy_rise: got %b want 1", if_a.t_busy); end
    nvec++; if (txd_a !== 1'b1) begin nerr++; $display("FAIL pre_start_idle: got %b want 1", txd_a); end
    capture(0, NB8, 40, bits, w);
    nvec++; if (w < 2 || w > 17) begin nerr++; $display("FAIL start_latency: got %0d clks want 2..17", w); end
    nvec++; if (bits !== frame8(8'hA5)) begin nerr++; $display("FAIL frame_a5: got %h want %h", bits, frame8(8'hA5)); end
    wait_busy_fall(0, n);
    nvec++; if (n !== 9) begin nerr++; $display("FAIL busy_fall_a5: got %0d want 9", n); end
    nvec++; if (txd_a !== 1'b1) begin nerr++; $display("FAIL idle_after_a5: got %b want 1", txd_a); end
  endtask

  task automatic test_parity;
    logic [15:0] bits;
    int w;
    int n;
`ifdef UART_TX_PARITY_EN
    write_byte(0, 8'hA5);
    capture(0, 11, 40, bits, w);
    nvec++; if (bits !== 16'b00000_1_0_10100101_0) begin nerr++; $display("FAIL par_even_a5: got %h want %h", bits, 16'b00000_1_0_10100101_0); end
    wait_busy_fall(0, n);
    nvec++; if (n !== 9) begin nerr++; $display("FAIL par_even_fall: got %0d want 9", n); end
    write_byte(2, 8'hA5);
    capture(2, 11, 40, bits, w);
    nvec++; if (bits !== 16'b00000_1_1_10100101_0) begin nerr++; $display("FAIL par_odd_a5: got %h want %h", bits, 16'b00000_1_1_10100101_0); end
`else
    write_byte(2, 8'hA5);
    capture(2, 10, 40, bits, w);
    nvec++; if (bits !== 16'b000000_1_10100101_0) begin nerr++; $display("FAIL nopar_a5: got %h want %h", bits, 16'b000000_1_10100101_0); end
`endif
    wait_busy_fall(2, n);
    nvec++; if (n !== 9) begin nerr++; $display("FAIL par_fall_c: got %0d want 9", n); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] bits;
    int w;
    int n;
    int lows;
    for (int i = 0; i < 20 && baud_enable !== 1'b1; i++) @(negedge clk);
    for (int k = 1; k <= 4; k++) write_byte(0, 8'(k));
    nvec++; if (if_a.t_full !== 1'b1) begin nerr++; $display("FAIL full_after_4: got %b want 1", if_a.t_full); end
    write_byte(0, 8'h55);
    nvec++; if (if_a.t_overrun !== 1'b1) begin nerr++; $display("FAIL overrun_set: got %b want 1", if_a.t_overrun); end
    nvec++; if (if_a.t_full !== 1'b1) begin nerr++; $display("FAIL full_after_drop: got %b want 1", if_a.t_full); end
    for (int k = 0; k < 4; k++) begin
      capture(0, NB8, (k == 0) ? 40 : 9, bits, w);
      nvec++; if (bits !== frame8(8'(k + 1))) begin nerr++; $display("FAIL b2b_frame%0d: got %h want %h", k, bits, frame8(8'(k + 1))); end
      if (k > 0) begin
        nvec++; if (w !== 9) begin nerr++; $display("FAIL b2b_gap%0d: got %0d want 9", k, w); end
      end
    end
    wait_busy_fall(0, n);
    nvec++; if (n !== 9) begin nerr++; $display("FAIL b2b_busy_fall: got %0d want 9", n); end
    lows = 0;
    repeat (48) begin
      @(negedge clk);
      if (txd_a !== 1'b1) lows++;
    end
    nvec++; if (lows !== 0) begin nerr++; $display("FAIL no_fifth_frame: got %0d low clks want 0", lows); end
    nvec++; if (if_a.t_overrun !== 1'b1) begin nerr++; $display("FAIL overrun_sticky: got %b want 1", if_a.t_overrun); end
  endtask

  task automatic test_width7_stop2;
    logic [15:0] bits;
    int w;
    int n;
    write_byte(1, 8'h7F);
    capture(1, NB7, 40, bits, w);
`ifdef UART_TX_PARITY_EN
    nvec++; if (bits !== 16'b00000_11_1_1111111_0) begin nerr++; $display("FAIL w7_frame: got %h want %h", bits, 16'b00000_11_1_1111111_0); end
`else
    nvec++; if (bits !== 16'b000000_11_1111111_0) begin nerr++; $display("FAIL w7_frame: got %h want %h", bits, 16'b000000_11_1111111_0); end
`endif
    wait_busy_fall(1, n);
    nvec++; if (n !== 9) begin nerr++; $display("FAIL w7_busy_fall: got %0d want 9", n); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] bits;
    int w;
    int n;
    write_byte(0, 8'h3C);
    write_byte(0, 8'h11);
    wait_start(0, 40, w);
    repeat (40) @(negedge clk);
    nvec++; if (txd_a !== 1'b0) begin nerr++; $display("FAIL mid_txd_pre: got %b want 0", txd_a); end
    reset = 1'b1;
    #1;
    nvec++; if (txd_a !== 1'b1) begin nerr++; $display("FAIL mid_rst_txd: got %b want 1", txd_a); end
    nvec++; if (if_a.t_busy !== 1'b0) begin nerr++; $display("FAIL mid_rst_busy: got %b want 0", if_a.t_busy); end
    nvec++; if (if_a.t_overrun !== 1'b0) begin nerr++; $display("FAIL mid_rst_ovr: got %b want 0", if_a.t_overrun); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    write_byte(0, 8'h96);
    capture(0, NB8, 40, bits, w);
    nvec++; if (bits !== frame8(8'h96)) begin nerr++; $display("FAIL after_rst_frame: got %h want %h", bits, frame8(8'h96)); end
    wait_busy_fall(0, n);
    nvec++; if (n !== 9) begin nerr++; $display("FAIL after_rst_fall: got %0d want 9", n); end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity();
    test_back_to_back();
    test_width7_stop2();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the existing single-byte UART transmitter. Serialises frames of configurable data width and stop-bit count, with optional parity.
- Buffers writes in an internal FIFO so the host can queue several characters back-to-back.
- Sits between the host/CPU write path and the txd pin. Bit timing comes from the shared baud-rate generator's baud_enable tick.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, ≥2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Only meaningful with UART_TX_PARITY_EN.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-high reset.
- baud_enable  in  1  single-clk pulse once per bit period, from the BRG.
- t_enable  in  1  write strobe; pushes data into the FIFO when !t_full.
- data  in  DATA_W  character to queue; LSB is transmitted first.
- txd  out  1  serial output; idles high.
- t_busy  out  1  high while the FIFO is non-empty or a frame is in flight.
- t_full  out  1  FIFO full.
- t_overrun  out  1  sticky; set when t_enable arrives while t_full. Cleared only by reset.

Behaviour:
- Reset (async, immediate):
  - txd=1, t_busy=0, t_full=0, t_overrun=0.
  - FIFO empty, FSM=IDLE, all counters 0.
  - Reset mid-frame aborts the frame; txd goes high immediately.
- FIFO write:
  - On clk with t_enable && !t_full, data is pushed.
  - t_enable && t_full: data is dropped, t_overrun<=1.
  - Full is evaluated pre-pop: a simultaneous pop does not free a slot in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO are both honoured; the count is unchanged.
- Pointers: log2(FIFO_DEPTH) bits plus one wrap bit. Wrap-around is natural modulo arithmetic. full = MSBs differ and LSBs equal.
- FSM states: IDLE, START, DATA, PARITY, STOP. Every transition happens only on a clk where baud_enable=1.
  - IDLE: txd=1. On baud_enable with FIFO non-empty: pop the head into shift reg sh[DATA_W-1:0], txd<=0, go to START. With FIFO empty, stay.
  - START: on baud_enable, txd<=sh[0], shift right, bit_cnt<=DATA_W-1, go to DATA.
  - DATA:
    - On baud_enable with bit_cnt≠0: txd<=sh[0], shift, bit_cnt-1.
    - On baud_enable with bit_cnt=0: go to PARITY if parity is enabled, else STOP with txd<=1 and stop_cnt<=STOP_BITS-1.
  - PARITY: txd = XOR of the frame data, inverted if PARITY_ODD. On baud_enable, go to STOP with txd<=1.
  - STOP: txd=1.
    - On baud_enable with stop_cnt≠0: stop_cnt-1.
    - On baud_enable with stop_cnt=0: if the FIFO is non-empty, pop and go directly to START with txd<=0 (back-to-back, no idle bit); else go to IDLE.
- Timing:
  - Frame length in baud periods: 1 + DATA_W + P + STOP_BITS, where P = 1 with parity, else 0.
  - Latency from a write into an empty idle block to the start-bit edge is 1 clk after the next baud_enable, at most one baud period plus 1 clk.
- t_busy = (state≠IDLE) | !empty. It is registered-equivalent: it rises the clk after the first push and falls the clk the final stop period ends.
- The data bus is sampled only at push; later changes to it have no effect.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: the PARITY state exists, and one parity bit is inserted after the data bits per PARITY_ODD.
- When undefined: the PARITY state and its logic are not compiled; PARITY_ODD is ignored; frames are 1+DATA_W+STOP_BITS bits.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP; 3-bit encoding).
  - Constants for idle line level (1'b1), start level (1'b0) and stop level (1'b1).
- One natural sub-module: sync_fifo, parametrised by width DATA_W and depth FIFO_DEPTH. It has push/pop/full/empty ports and is reusable by the receiver.

Test Plan:
- 8N1, write 0xA5 once, baud_enable every 16 clks → txd period sequence 0,1,0,1,0,0,1,0,1,1 then idle high; t_busy high from the clk after the write to the end of the stop bit.
- Parity enabled, even, 0xA5 → parity bit 0; with PARITY_ODD=1 → parity bit 1; 11 bit periods per frame.
- Write 0x01,0x02,0x03,0x04 on consecutive clks (depth 4) → all accepted; t_full=1 after the 4th; frames are sent back-to-back with the start bit immediately following the stop bit.
- A 5th write while full (0x55) → dropped; t_overrun=1 and stays set; only 4 frames are transmitted.
- DATA_W=7, STOP_BITS=2, write 0x7F → 0, seven 1s, 1, 1 (10 periods).
- Assert reset mid-DATA → txd=1 immediately; t_busy=0; FIFO empty; a new write afterwards transmits correctly.
